obstacle_scheduler: RTL and testbench



---
 rtl/space_pkg.sv | 15 +
 rtl/lfsr16.sv | 16 +
 rtl/obstacle_scheduler.sv | 162 ++++++++++++++++
 tb/tb_obstacle_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/space_pkg.sv
// Shared game-level types and screen constants for the obstacle scheduler.
package space_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HIT  = 2'd2
  } game_state_t;

  localparam int SCREEN_CORDW = 16;
  localparam int H_RES        = 640;
  localparam int V_RES        = 480;
  localparam int SCORE_MAX    = 999;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1, loaded with seed on reset.
module lfsr16 (
  input  logic        clk_pix,
  input  logic        rst_n,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  localparam logic [15:0] TAPS = 16'hB400;

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) q <= seed;
    else        q <= {1'b0, q[15:1]} ^ (q[0] ? TAPS : 16'h0000);
  end

endmodule

// File: rtl/obstacle_scheduler.sv
// Obstacle slot allocator, mover and IDLE/RUN/HIT game FSM.
// Optional SCHED_SPEEDUP_EN: fall speed grows with score (SPEED + score/100, max 8).
module obstacle_scheduler
  import space_pkg::*;
#(
  parameter int          N_OBS        = 4,
  parameter int          SCREEN_CORDW = space_pkg::SCREEN_CORDW,
  parameter int          H_RES        = space_pkg::H_RES,
  parameter int          V_RES        = space_pkg::V_RES,
  parameter int          OBS_SIZE     = 40,
  parameter int          SPEED        = 2,
  parameter int          SPAWN_GAP    = 60,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic                          clk_pix,
  input  logic                          rst_n,
  input  logic                          frame,
  input  logic                          start,
  input  logic                          collision,
  output logic [N_OBS*SCREEN_CORDW-1:0] obs_x,
  output logic [N_OBS*SCREEN_CORDW-1:0] obs_y,
  output logic [N_OBS-1:0]              obs_en,
  output logic [1:0]                    state,
  output logic [9:0]                    score
);

  localparam int                    LIM        = H_RES - OBS_SIZE;
  localparam logic [9:0]            LIM_V      = 10'(LIM);
  localparam logic [SCREEN_CORDW:0] V_LIM      = (SCREEN_CORDW + 1)'(V_RES);
  localparam int                    GAP_W      = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
  localparam logic [GAP_W-1:0]      GAP_RELOAD = GAP_W'(SPAWN_GAP - 1);

  if (LIM < 512 || LIM > 1023) begin : g_bad_lim
    $error("obstacle_scheduler: H_RES-OBS_SIZE must lie in 512..1023");
  end
  if (SEED == 16'h0000) begin : g_bad_seed
    $error("obstacle_scheduler: SEED must be nonzero");
  end

  function automatic logic [SCREEN_CORDW-1:0] spawn_x(input logic [9:0] v);
    logic [9:0] r;
    r = (v >= LIM_V) ? (v - LIM_V) : v;
    return SCREEN_CORDW'(r);
  endfunction

  function automatic logic [9:0] sat_inc(input logic [9:0] s);
    return (s >= 10'(SCORE_MAX)) ? 10'(SCORE_MAX) : (s + 10'd1);
  endfunction

  game_state_t                          state_q, state_d;
  logic [N_OBS-1:0][SCREEN_CORDW-1:0]   x_q, x_d, y_q, y_d;
  logic [N_OBS-1:0]                     en_q, en_d;
  logic [9:0]                           score_q, score_d;
  logic [GAP_W-1:0]                     gap_q, gap_d;
  logic [15:0]                          lfsr_q;
  logic [SCREEN_CORDW:0]                spd;
  logic [SCREEN_CORDW:0]                ny;
  logic                                 found;
  logic                                 unused_lfsr;

  lfsr16 u_lfsr (
    .clk_pix (clk_pix),
    .rst_n   (rst_n),
    .seed    (SEED),
    .q       (lfsr_q)
  );

  // Only the low ten bits feed the spawn position.
  assign unused_lfsr = ^lfsr_q[15:10];

`ifdef SCHED_SPEEDUP_EN
  function automatic logic [SCREEN_CORDW:0] speed_for(input logic [9:0] s);
    int t;
    t = SPEED + int'(s / 10'd100);
    if (t > 8) t = 8;
    return (SCREEN_CORDW + 1)'(t);
  endfunction

  assign spd = speed_for(score_q);
`else
  assign spd = (SCREEN_CORDW + 1)'(SPEED);
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    en_d    = en_q;
    score_d = score_q;
    gap_d   = gap_q;
    found   = 1'b0;
    ny      = '0;
    unique case (state_q)
      IDLE, HIT: begin
        if (start) begin
          state_d = RUN;
          x_d     = '0;
          y_d     = '0;
          en_d    = '0;
          score_d = '0;
          gap_d   = '0;
        end
      end
      RUN: begin
        if (frame && collision) begin
          state_d = HIT;
        end else if (frame) begin
          for (int i = 0; i < N_OBS; i++) begin
            if (en_q[i]) begin
              ny     = {1'b0, y_q[i]} + spd;
              y_d[i] = ny[SCREEN_CORDW-1:0];
              if (ny >= V_LIM) begin
                en_d[i] = 1'b0;
                score_d = sat_inc(score_d);
              end
            end
          end
          // Free slots are judged on en_q, so a slot retired this frame waits a frame.
          if (gap_q == '0) begin
            for (int i = 0; i < N_OBS; i++) begin
              if (!en_q[i] && !found) begin
                found   = 1'b1;
                x_d[i]  = spawn_x(lfsr_q[9:0]);
                y_d[i]  = '0;
                en_d[i] = 1'b1;
              end
            end
            if (found) gap_d = GAP_RELOAD;
          end else begin
            gap_d = gap_q - GAP_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      en_q    <= '0;
      score_q <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      en_q    <= en_d;
      score_q <= score_d;
      gap_q   <= gap_d;
    end
  end

  assign obs_x  = x_q;
  assign obs_y  = y_q;
  assign obs_en = en_q;
  assign state  = state_q;
  assign score  = score_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Scoreboard bench: stimulus queues expected values per frame/start pulse, a monitor compares.
module tb_obstacle_scheduler;
  import space_pkg::*;

  localparam int W = 16;
  localparam int N = 4;
  localparam int K_STATE = 0, K_SCORE = 1, K_EN = 2, K_X = 3, K_Y = 4, K_XLT = 5, K_ZERO = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic frame_a, start_a, coll_a, frame_b, start_b, coll_b;
  logic [N*W-1:0] x_a, y_a, x_b, y_b;
  logic [N-1:0]   en_a, en_b;
  logic [1:0]     st_a, st_b;
  logic [9:0]     sc_a, sc_b;

  obstacle_scheduler dut_a (
    .clk_pix(clk), .rst_n(rst_n), .frame(frame_a), .start(start_a), .collision(coll_a),
    .obs_x(x_a), .obs_y(y_a), .obs_en(en_a), .state(st_a), .score(sc_a)
  );

  obstacle_scheduler #(.V_RES(8), .SPAWN_GAP(1)) dut_b (
    .clk_pix(clk), .rst_n(rst_n), .frame(frame_b), .start(start_b), .collision(coll_b),
    .obs_x(x_b), .obs_y(y_b), .obs_en(en_b), .state(st_b), .score(sc_b)
  );

  typedef struct {
    int          dut;
    int          txn;
    int          kind;
    int          idx;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t q[$];
  int   iss [2];
  int   seen [2];
  int   checks   = 0;
  int   failures = 0;

  // Reference Galois LFSR (seed 0xACE1, taps 0xB400) to predict spawn positions of dut_a.
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  function automatic int spx(input logic [15:0] l);
    int v;
    v = int'(l[9:0]);
    return (v >= 600) ? v - 600 : v;
  endfunction

  function automatic logic [31:0] field(input int d, input int k, input int i);
    logic [N*W-1:0] xs, ys;
    xs = (d == 0) ? x_a : x_b;
    ys = (d == 0) ? y_a : y_b;
    case (k)
      K_STATE: return 32'((d == 0) ? st_a : st_b);
      K_SCORE: return 32'((d == 0) ? sc_a : sc_b);
      K_EN:    return 32'((d == 0) ? en_a : en_b);
      K_X:     return 32'(xs[i*W +: W]);
      K_Y:     return 32'(ys[i*W +: W]);
      K_XLT:   return {31'b0, (xs[i*W +: W] < 16'd600)};
      default: return {31'b0, (xs == '0) && (ys == '0)};
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst_n) begin
      if (frame_a || start_a) seen[0] <= seen[0] + 1;
      if (frame_b || start_b) seen[1] <= seen[1] + 1;
    end
  end

  initial begin
    chk_t        c;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].txn <= seen[q[0].dut]) begin
        c   = q.pop_front();
        act = field(c.dut, c.kind, c.idx);
        checks++;
        if (act !== c.exp) begin
          failures++;
          $display("FAIL %s: got %0d expected %0d", c.name, act, c.exp);
        end
      end
    end
  end

  task automatic chk(input int d, input int k, input int i, input int e, input string nm,
                     input bit now = 1'b0);
    chk_t c;
    c.dut  = d;
    c.txn  = now ? iss[d] : iss[d] + 1;
    c.kind = k;
    c.idx  = i;
    c.exp  = 32'(e);
    c.name = nm;
    q.push_back(c);
  endtask

  task automatic pulse(input int d, input bit f, input bit s, input bit col, input int idle);
    if (d == 0) begin
      frame_a = f; start_a = s; coll_a = col;
    end else begin
      frame_b = f; start_b = s;
    end
    iss[d]++;
    @(posedge clk); #1;
    frame_a = 0; start_a = 0; coll_a = 0; frame_b = 0; start_b = 0;
    repeat (idle) begin @(posedge clk); #1; end
  endtask

  task automatic frames(input int d, input int n);
    repeat (n) pulse(d, 1'b1, 1'b0, 1'b0, (d == 0) ? 3 : 1);
  endtask

  initial begin
    int ex0, ex1, ex3, ex0b, exr;
    iss[0] = 0; iss[1] = 0; seen[0] = 0; seen[1] = 0;
    rst_n = 0; frame_a = 0; start_a = 0; coll_a = 0; frame_b = 0; start_b = 0; coll_b = 0;
    chk(0, K_STATE, 0, 0, "reset_state", 1'b1);
    chk(0, K_SCORE, 0, 0, "reset_score", 1'b1);
    chk(0, K_EN,    0, 0, "reset_en",    1'b1);
    chk(0, K_ZERO,  0, 1, "reset_xy",    1'b1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    repeat (2) begin @(posedge clk); #1; end

    chk(0, K_STATE, 0, 0, "idle_frame_state");
    chk(0, K_EN,    0, 0, "idle_frame_en");
    pulse(0, 1, 0, 0, 3);
    chk(0, K_STATE, 0, 1, "start_state");
    chk(0, K_EN,    0, 0, "start_frame_ignored_en");
    chk(0, K_SCORE, 0, 0, "start_score");
    pulse(0, 1, 1, 0, 3);

    ex0 = spx(m_lfsr);
    chk(0, K_EN,  0, 1,   "f1_en");
    chk(0, K_Y,   0, 0,   "f1_y0");
    chk(0, K_X,   0, ex0, "f1_x0");
    chk(0, K_XLT, 0, 1,   "f1_x0_range");
    pulse(0, 1, 0, 0, 3);
    frames(0, 58);
    chk(0, K_EN, 0, 1,   "f60_no_spawn_en");
    chk(0, K_Y,  0, 118, "f60_y0");
    pulse(0, 1, 0, 0, 3);
    ex1 = spx(m_lfsr);
    chk(0, K_EN, 0, 3,   "f61_en");
    chk(0, K_Y,  1, 0,   "f61_y1");
    chk(0, K_Y,  0, 120, "f61_y0");
    chk(0, K_X,  1, ex1, "f61_x1");
    pulse(0, 1, 0, 0, 3);
    frames(0, 39);
    chk(0, K_STATE, 0, 1,   "run_start_ignored_state");
    chk(0, K_EN,    0, 3,   "run_start_ignored_en");
    chk(0, K_Y,     0, 198, "run_start_ignored_y0");
    pulse(0, 0, 1, 0, 3);
    frames(0, 20);
    chk(0, K_EN, 0, 7,   "f121_en");
    chk(0, K_Y,  0, 240, "f121_y0");
    pulse(0, 1, 0, 0, 3);
    frames(0, 59);
    ex3 = spx(m_lfsr);
    chk(0, K_EN, 0, 15,  "f181_en");
    chk(0, K_Y,  0, 360, "f181_y0");
    chk(0, K_X,  3, ex3, "f181_x3");
    pulse(0, 1, 0, 0, 3);
    frames(0, 58);
    chk(0, K_Y,     0, 478, "f240_y0");
    chk(0, K_SCORE, 0, 0,   "f240_score");
    pulse(0, 1, 0, 0, 3);
    chk(0, K_EN,    0, 14, "f241_retire_en");
    chk(0, K_SCORE, 0, 1,  "f241_score");
    pulse(0, 1, 0, 0, 3);
    ex0b = spx(m_lfsr);
    chk(0, K_EN, 0, 15,   "f242_respawn_en");
    chk(0, K_Y,  0, 0,    "f242_y0");
    chk(0, K_X,  0, ex0b, "f242_x0");
    chk(0, K_Y,  1, 362,  "f242_y1");
    pulse(0, 1, 0, 0, 3);

    chk(0, K_STATE, 0, 2,   "hit_state");
    chk(0, K_Y,     1, 362, "hit_y1");
    chk(0, K_SCORE, 0, 1,   "hit_score");
    pulse(0, 1, 0, 1, 3);
    for (int k = 0; k < 9; k++) pulse(0, 1, 0, k[0], 3);
    chk(0, K_STATE, 0, 2,    "hit10_state");
    chk(0, K_Y,     0, 0,    "hit10_y0");
    chk(0, K_Y,     1, 362,  "hit10_y1");
    chk(0, K_X,     0, ex0b, "hit10_x0");
    chk(0, K_X,     1, ex1,  "hit10_x1");
    chk(0, K_SCORE, 0, 1,    "hit10_score");
    chk(0, K_EN,    0, 15,   "hit10_en");
    pulse(0, 1, 0, 0, 3);

    chk(0, K_STATE, 0, 1, "restart_state");
    chk(0, K_EN,    0, 0, "restart_en");
    chk(0, K_SCORE, 0, 0, "restart_score");
    chk(0, K_ZERO,  0, 1, "restart_xy");
    pulse(0, 1, 1, 0, 3);
    exr = spx(m_lfsr);
    chk(0, K_EN, 0, 1,   "restart_spawn_en");
    chk(0, K_X,  0, exr, "restart_spawn_x0");
    pulse(0, 1, 0, 0, 3);
    frames(0, 1);
    chk(0, K_Y, 0, 4, "pre_reset_y0");
    pulse(0, 1, 0, 0, 3);

    #2 rst_n = 0;
    chk(0, K_STATE, 0, 0, "async_reset_state", 1'b1);
    chk(0, K_EN,    0, 0, "async_reset_en",    1'b1);
    chk(0, K_SCORE, 0, 0, "async_reset_score", 1'b1);
    chk(0, K_ZERO,  0, 1, "async_reset_xy",    1'b1);
    @(posedge clk); @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;

    chk(1, K_STATE, 0, 1, "b_start_state");
    pulse(1, 0, 1, 0, 1);
    frames(1, 3);
    chk(1, K_EN, 0, 15, "b_f4_full");
    chk(1, K_Y,  0, 6,  "b_f4_y0");
    chk(1, K_Y,  3, 0,  "b_f4_y3");
    pulse(1, 1, 0, 0, 1);
    chk(1, K_EN,    0, 14, "b_f5_no_spawn_en");
    chk(1, K_SCORE, 0, 1,  "b_f5_score");
    chk(1, K_Y,     1, 6,  "b_f5_y1");
    pulse(1, 1, 0, 0, 1);
    chk(1, K_EN,    0, 13, "b_f6_reuse_en");
    chk(1, K_Y,     0, 0,  "b_f6_y0");
    chk(1, K_SCORE, 0, 2,  "b_f6_score");
    pulse(1, 1, 0, 0, 1);
    chk(1, K_EN, 0, 11, "b_f7_en");
    pulse(1, 1, 0, 0, 1);
    frames(1, 2);
    chk(1, K_EN,    0, 14, "b_f10_en");
    chk(1, K_SCORE, 0, 5,  "b_f10_score");
    pulse(1, 1, 0, 0, 1);
    frames(1, 1240);
    chk(1, K_SCORE, 0, 998, "b_f1251_score");
    pulse(1, 1, 0, 0, 1);
    chk(1, K_SCORE, 0, 999, "b_f1252_score");
    pulse(1, 1, 0, 0, 1);
    chk(1, K_SCORE, 0, 999, "b_f1253_sat");
    pulse(1, 1, 0, 0, 1);
    chk(1, K_SCORE, 0, 999, "b_f1254_sat");
    pulse(1, 1, 0, 0, 1);
    chk(1, K_SCORE, 0, 999, "b_f1255_sat");
    pulse(1, 1, 0, 0, 1);

    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (st_a !== 2'd0) begin
      failures++;
      $display("FAIL final_a_state: got %0d expected 0", st_a);
    end
    checks++;
    if (en_a !== 4'd0) begin
      failures++;
      $display("FAIL final_a_en: got %0d expected 0", en_a);
    end
    checks++;
    if (sc_a !== 10'd0) begin
      failures++;
      $display("FAIL final_a_score: got %0d expected 0", sc_a);
    end
    checks++;
    if ((x_a !== '0) || (y_a !== '0)) begin
      failures++;
      $display("FAIL final_a_xy: coordinates not zero");
    end
    checks++;
    if (st_b !== 2'd1) begin
      failures++;
      $display("FAIL final_b_state: got %0d expected 1", st_b);
    end
    checks++;
    if (sc_b !== 10'd999) begin
      failures++;
      $display("FAIL final_b_score: got %0d expected 999", sc_b);
    end
    while (q.size() > 0) begin
      chk_t c;
      c = q.pop_front();
      checks++;
      failures++;
      $display("FAIL %s: never compared, expected %0d", c.name, c.exp);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
